// File: rtl/add_sub_reservation_station.sv
// Add/sub reservation station: holds dispatched add/sub ops until op1, op2 and
// XER are available (directly or via CDB snoop) and issues the oldest ready op.
package add_sub_pkg;
    typedef struct packed {
        logic       subtract;
        logic [1:0] carry_in_sel;
        logic       set_ca;
        logic       set_ov;
        logic       set_cr0;
    } add_sub_decode_t;
endpackage

module add_sub_reservation_station
    import add_sub_pkg::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int RS_ENTRIES  = 4,
    parameter int RS_ID_BASE  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  logic [4:0]             dispatch_reg_addr,
    input  add_sub_decode_t        dispatch_control,
    input  logic                   dispatch_op1_valid,
    input  logic                   dispatch_op2_valid,
    input  logic                   dispatch_xer_valid,
    input  logic [31:0]            dispatch_op1,
    input  logic [31:0]            dispatch_op2,
    input  logic [31:0]            dispatch_xer,
    input  logic [RS_ID_WIDTH-1:0] dispatch_op1_tag,
    input  logic [RS_ID_WIDTH-1:0] dispatch_op2_tag,
    input  logic [RS_ID_WIDTH-1:0] dispatch_xer_tag,
    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_tag,
    input  logic [31:0]            cdb_result,
    input  logic [31:0]            cdb_xer,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id,
    output logic [4:0]             issue_reg_addr,
    output logic [31:0]            issue_op1,
    output logic [31:0]            issue_op2,
    output logic [31:0]            issue_xer,
    output add_sub_decode_t        issue_control
);

    localparam int IDX_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

    logic [RS_ENTRIES-1:0]  ent_valid;
    logic [RS_ENTRIES-1:0]  op1_ok;
    logic [RS_ENTRIES-1:0]  op2_ok;
    logic [RS_ENTRIES-1:0]  xer_ok;
    logic [31:0]            op1_val [RS_ENTRIES];
    logic [31:0]            op2_val [RS_ENTRIES];
    logic [31:0]            xer_val [RS_ENTRIES];
    logic [RS_ID_WIDTH-1:0] op1_tag [RS_ENTRIES];
    logic [RS_ID_WIDTH-1:0] op2_tag [RS_ENTRIES];
    logic [RS_ID_WIDTH-1:0] xer_tag [RS_ENTRIES];
    logic [4:0]             reg_addr_q [RS_ENTRIES];
    add_sub_decode_t        ctrl_q [RS_ENTRIES];

    // older[i][j] set means entry i was dispatched before entry j
    logic [RS_ENTRIES-1:0]  older [RS_ENTRIES];
    logic [RS_ENTRIES-1:0]  older_col [RS_ENTRIES];

    logic [RS_ENTRIES-1:0]  ready;
    logic [RS_ENTRIES-1:0]  sel_oh;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       free_idx;
    logic                   any_ready;
    logic                   issue_load;
    logic                   issue_open;
    logic                   disp_fire;

    logic byp_op1;
    logic byp_op2;
    logic byp_xer;

    always_comb begin
        ready = ent_valid & op1_ok & op2_ok & xer_ok;
        any_ready = |ready;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            older_col[i] = '0;
            for (int j = 0; j < RS_ENTRIES; j++) begin
                older_col[i][j] = older[j][i];
            end
        end
        sel_idx = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            sel_oh[i] = ready[i] && !(|(ready & older_col[i]));
            if (sel_oh[i]) sel_idx = IDX_W'(i);
        end
        free_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid[i]) free_idx = IDX_W'(i);
        end
        dispatch_ready = ~&ent_valid;
        disp_fire = dispatch_valid && dispatch_ready;
        issue_open = !issue_valid || issue_ready;
        issue_load = issue_open && any_ready;
        byp_op1 = cdb_valid && (cdb_tag == dispatch_op1_tag);
        byp_op2 = cdb_valid && (cdb_tag == dispatch_op2_tag);
        byp_xer = cdb_valid && (cdb_tag == dispatch_xer_tag);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ent_valid      <= '0;
            op1_ok         <= '0;
            op2_ok         <= '0;
            xer_ok         <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) older[i] <= '0;
            issue_valid    <= 1'b0;
            issue_rs_id    <= '0;
            issue_reg_addr <= '0;
            issue_op1      <= '0;
            issue_op2      <= '0;
            issue_xer      <= '0;
            issue_control  <= '0;
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (ent_valid[i] && cdb_valid) begin
                    if (!op1_ok[i] && op1_tag[i] == cdb_tag) begin
                        op1_ok[i]  <= 1'b1;
                        op1_val[i] <= cdb_result;
                    end
                    if (!op2_ok[i] && op2_tag[i] == cdb_tag) begin
                        op2_ok[i]  <= 1'b1;
                        op2_val[i] <= cdb_result;
                    end
                    if (!xer_ok[i] && xer_tag[i] == cdb_tag) begin
                        xer_ok[i]  <= 1'b1;
                        xer_val[i] <= cdb_xer;
                    end
                end
            end

            if (issue_load) begin
                ent_valid[sel_idx] <= 1'b0;
                issue_valid    <= 1'b1;
                issue_rs_id    <= RS_ID_WIDTH'(RS_ID_BASE) + RS_ID_WIDTH'(sel_idx);
                issue_reg_addr <= reg_addr_q[sel_idx];
                issue_op1      <= op1_val[sel_idx];
                issue_op2      <= op2_val[sel_idx];
                issue_xer      <= xer_val[sel_idx];
                issue_control  <= ctrl_q[sel_idx];
            end else if (issue_open) begin
                issue_valid <= 1'b0;
            end

            // The free slot is never the one being issued, so no write conflict
            if (disp_fire) begin
                ent_valid[free_idx]  <= 1'b1;
                reg_addr_q[free_idx] <= dispatch_reg_addr;
                ctrl_q[free_idx]     <= dispatch_control;
                op1_tag[free_idx]    <= dispatch_op1_tag;
                op2_tag[free_idx]    <= dispatch_op2_tag;
                xer_tag[free_idx]    <= dispatch_xer_tag;
                op1_ok[free_idx]     <= dispatch_op1_valid || byp_op1;
                op2_ok[free_idx]     <= dispatch_op2_valid || byp_op2;
                xer_ok[free_idx]     <= dispatch_xer_valid || byp_xer;
                op1_val[free_idx]    <= dispatch_op1_valid ? dispatch_op1 : cdb_result;
                op2_val[free_idx]    <= dispatch_op2_valid ? dispatch_op2 : cdb_result;
                xer_val[free_idx]    <= dispatch_xer_valid ? dispatch_xer : cdb_xer;
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    older[free_idx][j] <= 1'b0;
                    if (j != int'(free_idx)) older[j][free_idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_sub_reservation_station.sv
// Directed bench for add_sub_reservation_station: issue latency, CDB capture,
// bypass, full/stall, age order across slot reuse, and flush.
module tb_add_sub_reservation_station;
    import add_sub_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            dispatch_valid;
    logic            dispatch_ready;
    logic [4:0]      dispatch_reg_addr;
    add_sub_decode_t dispatch_control;
    logic            dispatch_op1_valid;
    logic            dispatch_op2_valid;
    logic            dispatch_xer_valid;
    logic [31:0]     dispatch_op1;
    logic [31:0]     dispatch_op2;
    logic [31:0]     dispatch_xer;
    logic [4:0]      dispatch_op1_tag;
    logic [4:0]      dispatch_op2_tag;
    logic [4:0]      dispatch_xer_tag;
    logic            cdb_valid;
    logic [4:0]      cdb_tag;
    logic [31:0]     cdb_result;
    logic [31:0]     cdb_xer;
    logic            issue_valid;
    logic            issue_ready;
    logic [4:0]      issue_rs_id;
    logic [4:0]      issue_reg_addr;
    logic [31:0]     issue_op1;
    logic [31:0]     issue_op2;
    logic [31:0]     issue_xer;
    add_sub_decode_t issue_control;

    int total = 0;
    int passed = 0;
    int failed = 0;

    add_sub_reservation_station #(
        .RS_ID_WIDTH(5),
        .RS_ENTRIES(4),
        .RS_ID_BASE(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .dispatch_valid(dispatch_valid),
        .dispatch_ready(dispatch_ready),
        .dispatch_reg_addr(dispatch_reg_addr),
        .dispatch_control(dispatch_control),
        .dispatch_op1_valid(dispatch_op1_valid),
        .dispatch_op2_valid(dispatch_op2_valid),
        .dispatch_xer_valid(dispatch_xer_valid),
        .dispatch_op1(dispatch_op1),
        .dispatch_op2(dispatch_op2),
        .dispatch_xer(dispatch_xer),
        .dispatch_op1_tag(dispatch_op1_tag),
        .dispatch_op2_tag(dispatch_op2_tag),
        .dispatch_xer_tag(dispatch_xer_tag),
        .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag),
        .cdb_result(cdb_result),
        .cdb_xer(cdb_xer),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_rs_id(issue_rs_id),
        .issue_reg_addr(issue_reg_addr),
        .issue_op1(issue_op1),
        .issue_op2(issue_op2),
        .issue_xer(issue_xer),
        .issue_control(issue_control)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [4:0] ra,
                       input logic v1, input logic [31:0] o1, input logic [4:0] t1,
                       input logic v2, input logic [31:0] o2, input logic [4:0] t2,
                       input logic vx, input logic [31:0] ox, input logic [4:0] tx);
        dispatch_valid     = 1'b1;
        dispatch_reg_addr  = ra;
        dispatch_op1_valid = v1;
        dispatch_op1       = o1;
        dispatch_op1_tag   = t1;
        dispatch_op2_valid = v2;
        dispatch_op2       = o2;
        dispatch_op2_tag   = t2;
        dispatch_xer_valid = vx;
        dispatch_xer       = ox;
        dispatch_xer_tag   = tx;
    endtask

    task automatic cdb(input logic v, input logic [4:0] t,
                       input logic [31:0] r, input logic [31:0] x);
        cdb_valid  = v;
        cdb_tag    = t;
        cdb_result = r;
        cdb_xer    = x;
    endtask

    initial begin
        add_sub_decode_t ctl;
        ctl = '{subtract: 1'b1, carry_in_sel: 2'b10, set_ca: 1'b1,
                set_ov: 1'b0, set_cr0: 1'b1};
        rst = 1'b1;
        flush = 1'b0;
        issue_ready = 1'b0;
        dispatch_control = '0;
        put(5'd0, 1'b0, 32'd0, 5'd31, 1'b0, 32'd0, 5'd31, 1'b0, 32'd0, 5'd31);
        dispatch_valid = 1'b0;
        cdb(1'b0, 5'd0, 32'd0, 32'd0);
        step();
        step();
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_issue_op1", issue_op1, 32'd0);
        check("rst_issue_rs_id", 32'(issue_rs_id), 32'd0);
        check("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
        rst = 1'b0;

        // Basic: all operands valid
        issue_ready = 1'b1;
        dispatch_control = ctl;
        put(5'd7, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0, 1'b1, 32'd0, 5'd0);
        step();
        dispatch_valid = 1'b0;
        check("t1_no_issue_yet", 32'(issue_valid), 32'd0);
        step();
        check("t1_issue_valid", 32'(issue_valid), 32'd1);
        check("t1_rs_id", 32'(issue_rs_id), 32'd0);
        check("t1_op1", issue_op1, 32'd5);
        check("t1_op2", issue_op2, 32'd7);
        check("t1_reg_addr", 32'(issue_reg_addr), 32'd7);
        check("t1_control", 32'(issue_control), 32'(ctl));
        step();
        check("t1_drain", 32'(issue_valid), 32'd0);
        dispatch_control = '0;

        // CDB capture after a wait; a non-matching tag must be ignored
        put(5'd3, 1'b0, 32'd0, 5'd9, 1'b1, 32'd3, 5'd0, 1'b1, 32'd0, 5'd0);
        step();
        dispatch_valid = 1'b0;
        cdb(1'b1, 5'd8, 32'hBAD, 32'hBAD);
        step();
        check("t2_wait1", 32'(issue_valid), 32'd0);
        cdb(1'b0, 5'd0, 32'd0, 32'd0);
        step();
        check("t2_wait2", 32'(issue_valid), 32'd0);
        cdb(1'b1, 5'd9, 32'h10, 32'h0);
        step();
        cdb(1'b0, 5'd0, 32'd0, 32'd0);
        check("t2_capture_edge", 32'(issue_valid), 32'd0);
        step();
        check("t2_issue_valid", 32'(issue_valid), 32'd1);
        check("t2_op1", issue_op1, 32'h10);
        check("t2_op2", issue_op2, 32'd3);
        step();
        check("t2_drain", 32'(issue_valid), 32'd0);

        // Dispatch/CDB bypass for op2 and xer
        put(5'd4, 1'b1, 32'd1, 5'd0, 1'b0, 32'd0, 5'd4, 1'b0, 32'd0, 5'd4);
        cdb(1'b1, 5'd4, 32'hFFFF_FFFF, 32'h2000_0000);
        step();
        dispatch_valid = 1'b0;
        cdb(1'b0, 5'd0, 32'd0, 32'd0);
        step();
        check("t3_issue_valid", 32'(issue_valid), 32'd1);
        check("t3_op2", issue_op2, 32'hFFFF_FFFF);
        check("t3_xer", issue_xer, 32'h2000_0000);
        check("t3_op1", issue_op1, 32'd1);
        step();
        check("t3_drain", 32'(issue_valid), 32'd0);

        // Fill with the unit stalled
        issue_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            put(5'(k), 1'b1, 32'd100 + 32'(k), 5'd0, 1'b1, 32'd0, 5'd0,
                1'b1, 32'd0, 5'd0);
            step();
        end
        check("t4_full", 32'(dispatch_ready), 32'd0);
        check("t4_hold_valid", 32'(issue_valid), 32'd1);
        check("t4_hold_op1", issue_op1, 32'd100);
        put(5'd9, 1'b1, 32'h999, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
        step();
        dispatch_valid = 1'b0;
        check("t4_stable_op1", issue_op1, 32'd100);
        check("t4_stable_rs_id", 32'(issue_rs_id), 32'd0);
        check("t4_still_full", 32'(dispatch_ready), 32'd0);
        issue_ready = 1'b1;
        #1;
        check("t4_full_during_issue", 32'(dispatch_ready), 32'd0);
        step();
        check("t4_d1_op1", issue_op1, 32'd101);
        check("t4_d1_rs_id", 32'(issue_rs_id), 32'd1);
        check("t4_ready_back", 32'(dispatch_ready), 32'd1);
        step();
        check("t4_d2_op1", issue_op1, 32'd102);
        check("t4_d2_rs_id", 32'(issue_rs_id), 32'd0);
        step();
        check("t4_d3_op1", issue_op1, 32'd103);
        check("t4_d3_rs_id", 32'(issue_rs_id), 32'd2);
        step();
        check("t4_d4_op1", issue_op1, 32'd104);
        check("t4_d4_rs_id", 32'(issue_rs_id), 32'd3);
        step();
        check("t4_drain", 32'(issue_valid), 32'd0);

        // Age order across reuse: C->e0, B(pending)->e1, D reuses e0
        put(5'd1, 1'b1, 32'hC, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
        step();
        put(5'd2, 1'b0, 32'd0, 5'd12, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
        step();
        check("t5_c_op1", issue_op1, 32'hC);
        check("t5_c_rs_id", 32'(issue_rs_id), 32'd0);
        put(5'd3, 1'b1, 32'hD, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
        cdb(1'b1, 5'd12, 32'h77, 32'd0);
        step();
        dispatch_valid = 1'b0;
        cdb(1'b0, 5'd0, 32'd0, 32'd0);
        check("t5_gap", 32'(issue_valid), 32'd0);
        step();
        check("t5_b_first_rs_id", 32'(issue_rs_id), 32'd1);
        check("t5_b_first_op1", issue_op1, 32'h77);
        step();
        check("t5_d_second_rs_id", 32'(issue_rs_id), 32'd0);
        check("t5_d_second_op1", issue_op1, 32'hD);
        step();
        check("t5_drain", 32'(issue_valid), 32'd0);

        // Flush with 3 valid entries and a held issue
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            put(5'(k), 1'b1, 32'd200 + 32'(k), 5'd0, 1'b1, 32'd0, 5'd0,
                1'b1, 32'd0, 5'd0);
            step();
        end
        check("t6_pre_valid", 32'(issue_valid), 32'd1);
        put(5'd9, 1'b1, 32'h555, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        dispatch_valid = 1'b0;
        check("t6_flush_valid", 32'(issue_valid), 32'd0);
        check("t6_flush_ready", 32'(dispatch_ready), 32'd1);
        issue_ready = 1'b1;
        step();
        check("t6_empty1", 32'(issue_valid), 32'd0);
        step();
        check("t6_empty2", 32'(issue_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
